// File: rtl/demux4_reg.sv
// demux4_reg: registered 1-to-4 demultiplexer with per-channel full flags,
// read strobes and a sticky overflow flag.
// Optional build macro DEMUX4_AUTOINC_EN: an internal 2-bit pointer picks the
// target channel and advances after every accepted write; Controlador is ignored.

// One holding register plus its full flag (VAZIO/CHEIO state).
module demux4_chan #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,    // write strobe already steered to this channel
  input  logic         rd,    // read/acknowledge strobe for this channel
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         rej    // write refused: channel full and not drained this cycle
);
  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;

  // Read clears the flag; an accepted write reloads data and wins over the read.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (rd) full_d = 1'b0;
    if (wr && (!full_q || rd)) begin
      data_d = din;
      full_d = 1'b1;
    end
  end

  // Channel state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;
  assign rej  = wr && full_q && !rd;
endmodule

module demux4_reg #(
  parameter int LARGURA = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [1:0]         Controlador,
  input  logic [LARGURA-1:0] Entrada,
  input  logic               Escrever,
  input  logic [3:0]         Ler,
  output logic [LARGURA-1:0] Saida1,
  output logic [LARGURA-1:0] Saida2,
  output logic [LARGURA-1:0] Saida3,
  output logic [LARGURA-1:0] Saida4,
  output logic [3:0]         Cheio,
  output logic               Erro,
  output logic [1:0]         Ponteiro
);
  logic [1:0]              tgt;
  logic [3:0]              wr_sel;
  logic [3:0]              rej;
  logic [3:0][LARGURA-1:0] dout;
  logic                    erro_q, erro_d;

`ifdef DEMUX4_AUTOINC_EN
  logic [1:0] ptr_q, ptr_d;
  logic       unused_ctrl;
  assign unused_ctrl = ^Controlador;
  assign tgt         = ptr_q;

  // Pointer advances only on an accepted write; 2-bit width gives the 3->0 wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (Escrever && !rej[ptr_q]) ptr_d = ptr_q + 2'd1;
  end

  // Target pointer register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end
`else
  assign tgt = Controlador;
`endif

  assign Ponteiro = tgt;

  // Steer the write strobe to the selected channel only.
  always_comb begin
    wr_sel      = 4'b0000;
    wr_sel[tgt] = Escrever;
  end

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_chan
      demux4_chan #(.W(LARGURA)) u_chan (
        .clk  (Clock),
        .rst  (Reset),
        .wr   (wr_sel[i]),
        .rd   (Ler[i]),
        .din  (Entrada),
        .dout (dout[i]),
        .full (Cheio[i]),
        .rej  (rej[i])
      );
    end
  endgenerate

  // Overflow flag is sticky until reset.
  always_comb begin
    erro_d = erro_q | (|rej);
  end

  // Overflow flag register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) erro_q <= 1'b0;
    else       erro_q <= erro_d;
  end

  assign Erro   = erro_q;
  assign Saida1 = dout[0];
  assign Saida2 = dout[1];
  assign Saida3 = dout[2];
  assign Saida4 = dout[3];
endmodule

// File: tb/tb_demux4_reg.sv
// Directed self-checking bench for demux4_reg (default or DEMUX4_AUTOINC_EN build).
module tb_demux4_reg;
  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] Controlador = 2'd0;
  logic [7:0] Entrada = 8'h00;
  logic       Escrever = 1'b0;
  logic [3:0] Ler = 4'b0000;
  logic [7:0] Saida1, Saida2, Saida3, Saida4;
  logic [3:0] Cheio;
  logic       Erro;
  logic [1:0] Ponteiro;

  int errs   = 0;
  int checks = 0;

  demux4_reg #(.LARGURA(8)) dut (
    .Clock(Clock), .Reset(Reset), .Controlador(Controlador), .Entrada(Entrada),
    .Escrever(Escrever), .Ler(Ler), .Saida1(Saida1), .Saida2(Saida2),
    .Saida3(Saida3), .Saida4(Saida4), .Cheio(Cheio), .Erro(Erro), .Ponteiro(Ponteiro)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    Escrever = 1'b0;
    Ler      = 4'b0000;
  endtask

  task automatic sync_reset();
    idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] d, input logic [3:0] rd);
    Controlador = ch;
    Entrada     = d;
    Escrever    = 1'b1;
    Ler         = rd;
    tick();
    idle();
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_saida1", Saida1, 8'h00);
    chk("rst_saida4", Saida4, 8'h00);
    chk("rst_cheio",  Cheio,  4'b0000);
    chk("rst_erro",   Erro,   1'b0);
    chk("rst_ptr",    Ponteiro, 2'd0);
    Reset = 1'b0;

`ifdef DEMUX4_AUTOINC_EN
    // Five writes with a drain of ch0 before the fifth
    wr(2'd3, 8'h01, 4'b0000); chk("ai_ptr1", Ponteiro, 2'd1);
    wr(2'd3, 8'h02, 4'b0000); chk("ai_ptr2", Ponteiro, 2'd2);
    wr(2'd3, 8'h03, 4'b0000); chk("ai_ptr3", Ponteiro, 2'd3);
    wr(2'd3, 8'h04, 4'b0000); chk("ai_ptr0", Ponteiro, 2'd0);
    chk("ai_cheio_full", Cheio, 4'b1111);
    Ler = 4'b0001; tick(); idle();
    chk("ai_cheio_drain", Cheio, 4'b1110);
    wr(2'd3, 8'h05, 4'b0000);
    chk("ai_ptr_wrap", Ponteiro, 2'd1);
    chk("ai_saida1", Saida1, 8'h05);
    chk("ai_saida2", Saida2, 8'h02);
    chk("ai_saida3", Saida3, 8'h03);
    chk("ai_saida4", Saida4, 8'h04);
    chk("ai_erro0",  Erro,   1'b0);
    // Rejected write: ch1 full, pointer holds
    wr(2'd0, 8'h66, 4'b0000);
    chk("ai_rej_ptr",  Ponteiro, 2'd1);
    chk("ai_rej_erro", Erro,     1'b1);
    chk("ai_rej_data", Saida2,   8'h02);
`else
    // Single write to ch2
    wr(2'd2, 8'h5A, 4'b0000);
    chk("w2_saida3", Saida3, 8'h5A);
    chk("w2_cheio",  Cheio,  4'b0100);
    chk("w2_erro",   Erro,   1'b0);
    chk("w2_saida1", Saida1, 8'h00);
    chk("w2_saida2", Saida2, 8'h00);
    chk("w2_saida4", Saida4, 8'h00);
    Controlador = 2'd1; #1;
    chk("ptr_comb1", Ponteiro, 2'd1);
    Controlador = 2'd3; #1;
    chk("ptr_comb3", Ponteiro, 2'd3);

    // Overwrite without read is refused, Erro sticky
    wr(2'd0, 8'h11, 4'b0000);
    chk("ow_first", Saida1, 8'h11);
    wr(2'd0, 8'h22, 4'b0000);
    chk("ow_keep",  Saida1, 8'h11);
    chk("ow_erro",  Erro,   1'b1);
    chk("ow_cheio", Cheio,  4'b0101);
    tick(); tick();
    chk("ow_sticky", Erro, 1'b1);

    // Read-and-refill on ch1
    sync_reset();
    chk("rr_rst_erro", Erro, 1'b0);
    wr(2'd1, 8'h33, 4'b0000);
    chk("rr_fill", Saida2, 8'h33);
    wr(2'd1, 8'h44, 4'b0010);
    chk("rr_saida2", Saida2, 8'h44);
    chk("rr_cheio",  Cheio,  4'b0010);
    chk("rr_erro",   Erro,   1'b0);
    Ler = 4'b0010; tick(); idle();
    chk("rd_cheio", Cheio,  4'b0000);
    chk("rd_hold",  Saida2, 8'h44);

    // Read of empty channels is ignored
    Ler = 4'b1111; tick(); idle();
    chk("rdempty_cheio", Cheio, 4'b0000);
    chk("rdempty_erro",  Erro,  1'b0);

    // Fill all, partial drain
    wr(2'd0, 8'hA0, 4'b0000);
    wr(2'd1, 8'hA1, 4'b0000);
    wr(2'd2, 8'hA2, 4'b0000);
    wr(2'd3, 8'hA3, 4'b0000);
    chk("fill_cheio", Cheio, 4'b1111);
    chk("fill_s4",    Saida4, 8'hA3);
    Ler = 4'b1010; tick(); idle();
    chk("drain_cheio", Cheio,  4'b0101);
    chk("drain_hold",  Saida2, 8'hA1);
    // Write ch1 while draining ch0 in the same cycle
    wr(2'd1, 8'hB1, 4'b0001);
    chk("mix_cheio",  Cheio,  4'b0110);
    chk("mix_saida2", Saida2, 8'hB1);
    chk("mix_erro",   Erro,   1'b0);
    // Refused write to full ch2
    wr(2'd2, 8'hC2, 4'b0000);
    chk("rej_saida3", Saida3, 8'hA2);
    chk("rej_erro",   Erro,   1'b1);
    wr(2'd0, 8'hD0, 4'b0000);
    wr(2'd3, 8'hD3, 4'b0000);
    chk("full_again", Cheio, 4'b1111);

    // Asynchronous reset mid-cycle
    #2 Reset = 1'b1;
    #1;
    chk("ar_cheio",  Cheio,  4'b0000);
    chk("ar_erro",   Erro,   1'b0);
    chk("ar_saida1", Saida1, 8'h00);
    chk("ar_saida3", Saida3, 8'h00);
    tick();
    Reset = 1'b0;
    wr(2'd3, 8'h77, 4'b0000);
    chk("post_saida4", Saida4, 8'h77);
    chk("post_cheio",  Cheio,  4'b1000);
    chk("post_erro",   Erro,   1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
